// File: rtl/apb3_cfg_pkg.sv
// Shared constants and the handshake state type for the APB3 3DNR configuration register bank.
package apb3_cfg_pkg;

  localparam int REG_CTRL        = 0;
  localparam int REG_STATUS      = 1;
  localparam int REG_CFG_BASE    = 2;
  localparam int CTRL_COMMIT_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb3_cfg_regbank_fsm.sv
// APB3 setup/wait/response handshake with a programmable wait-state counter.
// Emits the access strobes and the word index toward the register storage.
module apb3_slv_fsm
  import apb3_cfg_pkg::*;
#(
  parameter int AW          = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] apb_addr,
  input  logic          apb_sel,
  input  logic          apb_enable,
  input  logic          apb_write,
  output logic          apb_ready,
  output logic [AW-3:0] idx,
  output logic          misalign,
  output logic          is_write,
  output logic          load_stb,
  output logic          rd_stb,
  output logic          wr_stb
);

  apb_state_e     state_r, state_s;
  logic [3:0]     cnt_r, cnt_s;
  logic           load_s;
  logic           ready_r;
  logic [AW-3:0]  idx_r;
  logic           misalign_r;
  logic           write_r;
  logic           setup_s;

  assign setup_s = apb_sel & ~apb_enable;

  // Next-state and wait-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (setup_s) begin
          if (WAIT_CYCLES == 0) begin
            state_s = RESP;
            load_s  = 1'b1;
          end else begin
            state_s = WAIT;
            cnt_s   = 4'(WAIT_CYCLES - 1);
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!apb_sel) begin
          state_s = IDLE;
        end else if (cnt_r == 4'd0) begin
          state_s = RESP;
          load_s  = 1'b1;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, counter, ready and captured transfer attributes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      ready_r    <= 1'b0;
      idx_r      <= '0;
      misalign_r <= 1'b0;
      write_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ready_r <= load_s;
      if (state_r == IDLE && setup_s) begin
        idx_r      <= apb_addr[AW-1:2];
        misalign_r <= (apb_addr[1:0] != 2'b00);
        write_r    <= apb_write;
      end
    end
  end

  // With zero wait states RESP is entered from IDLE, before the capture is visible.
  assign idx       = (state_r == IDLE) ? apb_addr[AW-1:2] : idx_r;
  assign misalign  = (state_r == IDLE) ? (apb_addr[1:0] != 2'b00) : misalign_r;
  assign is_write  = (state_r == IDLE) ? apb_write : write_r;
  assign apb_ready = ready_r;
  assign load_stb  = load_s;
  assign rd_stb    = load_s & ~is_write;
  assign wr_stb    = (state_r == RESP) & write_r;

endmodule

// File: rtl/apb3_cfg_regbank.sv
// APB3 register bank holding shadow and frame-synchronous active 3DNR configuration.
// Optional macro APB_REG_ACTIVE_RDBACK_EN maps active-copy readback at indices NREG+2..2*NREG-1.
module apb3_cfg_regbank
  import apb3_cfg_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int NREG        = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AW-1:0]            apb_addr,
  input  logic                     apb_sel,
  input  logic                     apb_enable,
  input  logic                     apb_write,
  input  logic [DW-1:0]            apb_wdata,
  output logic [DW-1:0]            apb_rdata,
  output logic                     apb_ready,
  output logic                     apb_slverr,
  input  logic                     frame_start,
  input  logic [DW-1:0]            hw_status,
  output logic [(NREG-2)*DW-1:0]   cfg_active,
  output logic                     commit_pend
);

  localparam int NCFG = NREG - REG_CFG_BASE;
  localparam int IW   = AW - 2;
  localparam int SW   = (NCFG > 1) ? $clog2(NCFG) : 1;

  logic [IW-1:0] idx;
  logic          misalign;
  logic          is_write;
  logic          load_stb;
  logic          rd_stb;
  logic          wr_stb;

  logic [DW-1:0] shadow_r [NCFG];
  logic [DW-1:0] active_r [NCFG];
  logic          commit_pend_r;
  logic [DW-1:0] rdata_r;
  logic          slverr_r;

  logic [DW-1:0] rd_data_s;
  logic          err_s;
  logic          wr_ok_s;
  logic [SW-1:0] cfg_sel_s;

  apb3_slv_fsm #(
    .AW          (AW),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .apb_addr   (apb_addr),
    .apb_sel    (apb_sel),
    .apb_enable (apb_enable),
    .apb_write  (apb_write),
    .apb_ready  (apb_ready),
    .idx        (idx),
    .misalign   (misalign),
    .is_write   (is_write),
    .load_stb   (load_stb),
    .rd_stb     (rd_stb),
    .wr_stb     (wr_stb)
  );

  assign cfg_sel_s = SW'(idx - IW'(REG_CFG_BASE));

`ifdef APB_REG_ACTIVE_RDBACK_EN
  logic [SW-1:0] act_sel_s;
  assign act_sel_s = SW'(idx - IW'(NREG + REG_CFG_BASE));
`endif

  // Address decode: read data mux and error classification.
  always_comb begin
    rd_data_s = '0;
    err_s     = 1'b0;
    if (misalign) begin
      err_s = 1'b1;
    end else if (idx == IW'(REG_CTRL)) begin
      rd_data_s = {{(DW-1){1'b0}}, commit_pend_r};
    end else if (idx == IW'(REG_STATUS)) begin
      rd_data_s = hw_status;
      err_s     = is_write;
    end else if (idx < IW'(NREG)) begin
      rd_data_s = shadow_r[cfg_sel_s];
`ifdef APB_REG_ACTIVE_RDBACK_EN
    end else if (idx >= IW'(NREG + REG_CFG_BASE) && idx < IW'(2 * NREG)) begin
      rd_data_s = active_r[act_sel_s];
      err_s     = is_write;
`endif
    end else begin
      err_s = 1'b1;
    end
  end

  assign wr_ok_s = wr_stb & ~err_s;

  // Shadow/active storage and commit handshake; the frame copy samples pre-write values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCFG; k++) begin
        shadow_r[k] <= '0;
        active_r[k] <= '0;
      end
      commit_pend_r <= 1'b0;
    end else begin
      if (frame_start && commit_pend_r) begin
        for (int k = 0; k < NCFG; k++) begin
          active_r[k] <= shadow_r[k];
        end
        commit_pend_r <= 1'b0;
      end
      if (wr_ok_s && idx == IW'(REG_CTRL) && apb_wdata[CTRL_COMMIT_BIT]) begin
        commit_pend_r <= 1'b1;
      end
      if (wr_ok_s && idx >= IW'(REG_CFG_BASE) && idx < IW'(NREG)) begin
        shadow_r[cfg_sel_s] <= apb_wdata;
      end
    end
  end

  // Response registers: loaded entering RESP, cleared otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r  <= '0;
      slverr_r <= 1'b0;
    end else if (load_stb) begin
      rdata_r  <= (rd_stb && !err_s) ? rd_data_s : '0;
      slverr_r <= err_s;
    end else begin
      rdata_r  <= '0;
      slverr_r <= 1'b0;
    end
  end

  for (genvar g = 0; g < NCFG; g++) begin : g_act
    assign cfg_active[g*DW +: DW] = active_r[g];
  end

  assign apb_rdata   = rdata_r;
  assign apb_slverr  = slverr_r;
  assign commit_pend = commit_pend_r;

endmodule
